sseg_scan_driver: RTL and testbench

SSEG_SCAN_DRIVER -- requirements
Module: sseg_scan_driver

---
 rtl/sseg_pkg.sv | 18 +
 rtl/hex_digit_decoder.sv | 15 +
 rtl/sseg_scan_driver.sv | 129 ++++++++++++
 tb/tb_sseg_scan_driver.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared constants for the multiplexed seven-segment scan driver:
// active-low segment table, blank pattern and legal digit-count range.
package sseg_pkg;

   localparam int NUM_DIGITS_MIN = 1;
   localparam int NUM_DIGITS_MAX = 8;

   localparam logic [7:0] SSEG_BLANK = 8'hFF;

   // Index is the hex nibble; bits are {g,f,e,d,c,b,a}, low = segment lit.
   localparam logic [6:0] SEG_TABLE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30,
      7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03,
      7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

// File: rtl/hex_digit_decoder.sv
// Combinational hex nibble plus decimal-point request to an active-low
// seven-segment pattern {dp,g,f,e,d,c,b,a}.
module hex_digit_decoder
   import sseg_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       dp,
   output logic [7:0] pattern
);

   always_comb begin
      pattern = {~dp, SEG_TABLE[nibble]};
   end

endmodule

// File: rtl/sseg_scan_driver.sv
// Time-multiplexed hex display driver with load-strobed shadow registers.
// Optional leading-zero blanking is enabled by defining SSEG_LEADING_ZERO_BLANK_EN.
module sseg_scan_driver
   import sseg_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int PRESCALE_BITS = 16
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [7:0]              sseg,
   output logic                    frame_start
);

   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   generate
      if (NUM_DIGITS < NUM_DIGITS_MIN || NUM_DIGITS > NUM_DIGITS_MAX) begin : g_bad_num_digits
         $error("sseg_scan_driver: NUM_DIGITS out of range");
      end
   endgenerate

   logic [PRESCALE_BITS-1:0] presc;
   logic [IDX_W-1:0]         idx;
   logic [4*NUM_DIGITS-1:0]  sh_value;
   logic [NUM_DIGITS-1:0]    sh_dp;
   logic [NUM_DIGITS-1:0]    sh_en;
   logic                     wrap_d;
   logic                     tick;

   logic [3:0]               sel_nibble;
   logic                     sel_dp;
   logic                     sel_en;
   logic                     show;
   logic [7:0]               dec_pattern;
   logic [NUM_DIGITS-1:0]    an_next;
   logic [7:0]               sseg_next;

   always_comb begin
      tick = (presc == '1);
   end

   // Timing state and shadow registers; reset wins over both load and tick.
   always_ff @(posedge clk) begin
      if (reset) begin
         presc    <= '0;
         idx      <= '0;
         sh_value <= '0;
         sh_dp    <= '0;
         sh_en    <= '0;
         wrap_d   <= 1'b0;
      end else begin
         presc  <= presc + PRESCALE_BITS'(1);
         wrap_d <= tick && (idx == IDX_LAST);
         if (tick) begin
            idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
         end
         if (load) begin
            sh_value <= value;
            sh_dp    <= dp;
            sh_en    <= digit_en;
         end
      end
   end

`ifdef SSEG_LEADING_ZERO_BLANK_EN
   logic sel_upper_zero;
`endif

   always_comb begin
      sel_nibble = '0;
      sel_dp     = 1'b0;
      sel_en     = 1'b0;
`ifdef SSEG_LEADING_ZERO_BLANK_EN
      sel_upper_zero = 1'b0;
`endif
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
         if (idx == IDX_W'(k)) begin
            sel_nibble = sh_value[4*k +: 4];
            sel_dp     = sh_dp[k];
            sel_en     = sh_en[k];
`ifdef SSEG_LEADING_ZERO_BLANK_EN
            sel_upper_zero = ((sh_value >> (4*k)) == '0);
`endif
         end
      end
   end

   hex_digit_decoder u_dec (
      .nibble  (sel_nibble),
      .dp      (sel_dp),
      .pattern (dec_pattern)
   );

   // A digit is blanked when every nibble from it upward is zero, except digit 0 and dp digits.
   always_comb begin
`ifdef SSEG_LEADING_ZERO_BLANK_EN
      show = sel_en && !((idx != '0) && !sel_dp && sel_upper_zero);
`else
      show = sel_en;
`endif
      an_next   = '1;
      sseg_next = SSEG_BLANK;
      if (show) begin
         an_next   = ~(NUM_DIGITS'(1) << idx);
         sseg_next = dec_pattern;
      end
   end

   // Output stage trails the scan index by one clock; frame_start rides with digit 0's first output cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         an          <= '1;
         sseg        <= SSEG_BLANK;
         frame_start <= 1'b0;
      end else begin
         an          <= an_next;
         sseg        <= sseg_next;
         frame_start <= wrap_d;
      end
   end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Self-checking bench for sseg_scan_driver (NUM_DIGITS=4, PRESCALE_BITS=2):
// fixed vectors, hand-written timing sequences and random traffic against a time-based model.
module tb_sseg_scan_driver;

   localparam int ND    = 4;
   localparam int PB    = 2;
   localparam int NPS   = 1 << PB;
   localparam int FRAME = ND * NPS;

   logic        clk = 1'b0;
   logic        reset;
   logic        load;
   logic [15:0] value;
   logic [3:0]  dp;
   logic [3:0]  digit_en;
   logic [3:0]  an;
   logic [7:0]  sseg;
   logic        frame_start;

   always #5 clk = ~clk;

   sseg_scan_driver #(
      .NUM_DIGITS    (ND),
      .PRESCALE_BITS (PB)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .load        (load),
      .value       (value),
      .dp          (dp),
      .digit_en    (digit_en),
      .an          (an),
      .sseg        (sseg),
      .frame_start (frame_start)
   );

   int unsigned tests = 0;
   int unsigned fails = 0;

   // Model: edges since reset release plus the shadow contents the display currently uses.
   int unsigned t = 0;
   logic [15:0] m_value = '0;
   logic [3:0]  m_dp    = '0;
   logic [3:0]  m_en    = '0;
   logic [3:0]  exp_an;
   logic [7:0]  exp_sseg;
   logic        exp_fs;

   typedef struct packed {
      logic [15:0] value;
      logic [3:0]  dp;
      logic [3:0]  en;
      logic [15:0] an_exp;
      logic [31:0] sseg_exp;
   } vec_t;

   vec_t vecs [5];

   function automatic logic [6:0] seg(input logic [3:0] n);
      case (n)
         4'h0: seg = 7'h40;  4'h1: seg = 7'h79;  4'h2: seg = 7'h24;  4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;  4'h5: seg = 7'h12;  4'h6: seg = 7'h02;  4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;  4'h9: seg = 7'h10;  4'hA: seg = 7'h08;  4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;  4'hD: seg = 7'h21;  4'hE: seg = 7'h06;  default: seg = 7'h0E;
      endcase
   endfunction

   task automatic model_expect();
      int unsigned d;
      logic [3:0]  nib;
      logic        blank;
      if (reset) begin
         exp_an   = '1;
         exp_sseg = 8'hFF;
         exp_fs   = 1'b0;
      end else begin
         d     = (t / NPS) % ND;
         nib   = 4'((m_value >> (4*d)) & 16'hF);
         blank = !m_en[d];
`ifdef SSEG_LEADING_ZERO_BLANK_EN
         if (d != 0 && !m_dp[d] && ((m_value >> (4*d)) == 16'h0)) blank = 1'b1;
`endif
         if (blank) begin
            exp_an   = '1;
            exp_sseg = 8'hFF;
         end else begin
            exp_an   = ~(4'b0001 << d);
            exp_sseg = {~m_dp[d], seg(nib)};
         end
         exp_fs = (t != 0) && (t % FRAME == 0);
      end
   endtask

   task automatic cycle(input string tag);
      model_expect();
      @(posedge clk);
      if (reset) begin
         t       = 0;
         m_value = '0;
         m_dp    = '0;
         m_en    = '0;
      end else begin
         if (load) begin
            m_value = value;
            m_dp    = dp;
            m_en    = digit_en;
         end
         t++;
      end
      @(negedge clk);
      tests++;
      if (an !== exp_an || sseg !== exp_sseg || frame_start !== exp_fs) begin
         fails++;
         $display("FAIL %s t=%0d: got an=%b sseg=%h fs=%b, expected an=%b sseg=%h fs=%b",
                  tag, t, an, sseg, frame_start, exp_an, exp_sseg, exp_fs);
      end
   endtask

   task automatic set_in(input logic r, input logic l, input logic [15:0] v,
                         input logic [3:0] p, input logic [3:0] e);
      reset    = r;
      load     = l;
      value    = v;
      dp       = p;
      digit_en = e;
   endtask

   int unsigned pulses;
   int          last_pulse;
   logic        gaps_ok;
   int unsigned blank_bad;

   initial begin
      vecs[0] = '{16'h10AF, 4'h0, 4'hF, {4'b0111, 4'b1011, 4'b1101, 4'b1110}, {8'hF9, 8'hC0, 8'h88, 8'h8E}};
      vecs[1] = '{16'h10AF, 4'h0, 4'b1011, {4'b0111, 4'b1111, 4'b1101, 4'b1110}, {8'hF9, 8'hFF, 8'h88, 8'h8E}};
`ifdef SSEG_LEADING_ZERO_BLANK_EN
      vecs[2] = '{16'h0005, 4'h0, 4'hF, {4'b1111, 4'b1111, 4'b1111, 4'b1110}, {8'hFF, 8'hFF, 8'hFF, 8'h92}};
      vecs[3] = '{16'h0005, 4'b0100, 4'hF, {4'b1111, 4'b1011, 4'b1111, 4'b1110}, {8'hFF, 8'h40, 8'hFF, 8'h92}};
`else
      vecs[2] = '{16'h0005, 4'h0, 4'hF, {4'b0111, 4'b1011, 4'b1101, 4'b1110}, {8'hC0, 8'hC0, 8'hC0, 8'h92}};
      vecs[3] = '{16'h0005, 4'b0100, 4'hF, {4'b0111, 4'b1011, 4'b1101, 4'b1110}, {8'hC0, 8'h40, 8'hC0, 8'h92}};
`endif
      vecs[4] = '{16'h8E3D, 4'b1001, 4'hF, {4'b0111, 4'b1011, 4'b1101, 4'b1110}, {8'h00, 8'h86, 8'hB0, 8'h21}};

      set_in(1'b1, 1'b0, '0, '0, '0);
      cycle("reset");

      // Fixed vectors: load right after reset, then check one full frame slot by slot.
      for (int v = 0; v < 5; v++) begin
         set_in(1'b1, 1'b0, '0, '0, '0);
         cycle("vec_reset");
         set_in(1'b0, 1'b1, vecs[v].value, vecs[v].dp, vecs[v].en);
         cycle("vec_load");
         load = 1'b0;
         while (t < FRAME) cycle("vec_wait");
         for (int j = 0; j < FRAME; j++) begin
            int d;
            d = j / NPS;
            cycle("vec_model");
            tests++;
            if (an !== vecs[v].an_exp[4*d +: 4] || sseg !== vecs[v].sseg_exp[8*d +: 8]) begin
               fails++;
               $display("FAIL vec%0d digit%0d: got an=%b sseg=%h, expected an=%b sseg=%h",
                        v, d, an, sseg, vecs[v].an_exp[4*d +: 4], vecs[v].sseg_exp[8*d +: 8]);
            end
         end
      end

      // Load coincident with a slot tick: the next digit must already show new data.
      set_in(1'b1, 1'b0, '0, '0, '0);
      cycle("tick_reset");
      set_in(1'b0, 1'b1, 16'h1111, 4'h0, 4'hF);
      cycle("tick_load1");
      load = 1'b0;
      while (t < NPS - 1) cycle("tick_wait");
      set_in(1'b0, 1'b1, 16'h2222, 4'h0, 4'hF);
      cycle("tick_load2");
      load = 1'b0;
      cycle("tick_next");
      tests++;
      if (an !== 4'b1101 || sseg !== 8'hA4) begin
         fails++;
         $display("FAIL load_on_tick: got an=%b sseg=%h, expected an=1101 sseg=a4", an, sseg);
      end

      // frame_start cadence over four frames.
      pulses     = 0;
      last_pulse = -1;
      gaps_ok    = 1'b1;
      for (int c = 0; c < 4 * FRAME; c++) begin
         cycle("fs_run");
         if (frame_start === 1'b1) begin
            pulses++;
            if (last_pulse >= 0 && c - last_pulse != FRAME) gaps_ok = 1'b0;
            last_pulse = c;
         end
      end
      tests++;
      if (pulses != 4 || !gaps_ok) begin
         fails++;
         $display("FAIL frame_start_rate: got %0d pulses (gaps_ok=%b), expected 4 pulses 16 apart",
                  pulses, gaps_ok);
      end

      // Mid-slot reset with load high: reset wins, shadows clear.
      while (t % NPS != 1) cycle("mid_wait");
      set_in(1'b1, 1'b1, 16'hFFFF, 4'hF, 4'hF);
      cycle("mid_reset");
      tests++;
      if (an !== 4'hF || sseg !== 8'hFF || frame_start !== 1'b0) begin
         fails++;
         $display("FAIL mid_reset: got an=%b sseg=%h fs=%b, expected an=1111 sseg=ff fs=0",
                  an, sseg, frame_start);
      end
      set_in(1'b0, 1'b0, 16'h1234, 4'h0, 4'hF);
      blank_bad = 0;
      for (int c = 0; c < FRAME + 4; c++) begin
         cycle("post_reset");
         if (an !== 4'hF || sseg !== 8'hFF) blank_bad++;
      end
      tests++;
      if (blank_bad != 0) begin
         fails++;
         $display("FAIL shadow_cleared: got %0d non-blank cycles, expected 0", blank_bad);
      end

      // Random traffic against the model.
      for (int c = 0; c < 1500; c++) begin
         set_in(($urandom_range(99) == 0), ($urandom_range(5) == 0),
                16'($urandom), 4'($urandom), 4'($urandom));
         if ($urandom_range(3) == 0) value = value & 16'h00FF;
         cycle("random");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
